// File: rtl/pipe_pkg.sv
// Shared control-payload types for the RV32 pipeline boundaries.
// Widths are exported so each pipe_stage_reg instance can size CTRL_W from its struct.
package pipe_pkg;

  typedef struct packed {
    logic pred_taken;
    logic fetch_fault;
  } if_id_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] mem_funct3;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;

  localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  // A bubble: every control bit deasserted.
  localparam logic [31:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid bit, control field (zeroed whenever empty) and data field.
// Flush beats load and clear for valid/ctrl; data is never touched by flush or clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 64,
  parameter int                 CTRL_W     = 8,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(NOP_CTRL);
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(NOP_CTRL);
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(NOP_CTRL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= RESET_DATA;
    end else if (load && !flush) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: main entry M drives the outputs; with SKID=1 a second entry S
// absorbs one beat so in_ready is purely registered. Only handshake steering lives here.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 64,
  parameter int                 CTRL_W     = 8,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0,
  parameter bit                 SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_in_ctrl;
  logic [DATA_W-1:0] m_data, s_data, m_in_data;
  logic              accept, consume, m_load, m_clear, m_from_s;

  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = m_valid & out_ready;
  assign m_clear   = consume & ~m_load;
  assign m_in_ctrl = m_from_s ? s_ctrl : in_ctrl;
  assign m_in_data = m_from_s ? s_data : in_data;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_main (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .load    (m_load),
    .clear   (m_clear),
    .in_ctrl (m_in_ctrl),
    .in_data (m_in_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  generate
    if (SKID) begin : g_skid
      logic m_free, s_load, s_clear;
      // M can take a new beat when it is empty or leaving this cycle; S always drains first.
      assign m_free   = ~m_valid | consume;
      assign m_load   = m_free & (s_valid | accept);
      assign m_from_s = s_valid;
      assign s_load   = accept & ~m_free;
      assign s_clear  = s_valid & m_free;
      assign in_ready = ~s_valid;

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .load    (s_load),
        .clear   (s_clear),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (s_valid),
        .ctrl    (s_ctrl),
        .data    (s_data)
      );
    end else begin : g_single
      assign m_load   = accept;
      assign m_from_s = 1'b0;
      assign s_valid  = 1'b0;
      assign s_ctrl   = '0;
      assign s_data   = '0;
      assign in_ready = ~m_valid | out_ready;
    end
  endgenerate

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=0 and a SKID=1 instance with shared stimulus; each is scored against a
// capacity-limited FIFO model (1 entry or 2 entries) that flush empties.
module tb_pipe_stage_reg;

  typedef struct {
    logic [7:0]  c;
    logic [63:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        rdy [2];
  logic        ov  [2];
  logic [7:0]  oc  [2];
  logic [63:0] od  [2];
  logic [1:0]  occ [2];

  int n_cmp = 0;
  int n_err = 0;

  beat_t mem [2][4];
  int    hd  [2] = '{0, 0};
  int    cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .RESET_DATA(64'h0), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .RESET_DATA(64'h0), .SKID(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
    .occupancy(occ[1])
  );

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 64'(ov[k]), 64'd0);
      chk("rst_out_ctrl",  k, 64'(oc[k]), 64'd0);
      chk("rst_out_data",  k, od[k], 64'd0);
      chk("rst_in_ready",  k, 64'(rdy[k]), 64'd1);
      chk("rst_occupancy", k, 64'(occ[k]), 64'd0);
    end
  endtask

  // Scoreboard/model: sampled mid-cycle, describes what the coming edge will do.
  always @(negedge clk) begin
    if (reset) begin
      cnt[0] = 0;
      cnt[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic exp_rdy;
        exp_rdy = (k == 1) ? (cnt[k] < 2) : (cnt[k] == 0 || out_ready);
        chk("in_ready",  k, 64'(rdy[k]), 64'(exp_rdy));
        chk("out_valid", k, 64'(ov[k]), 64'(cnt[k] != 0));
        chk("occupancy", k, 64'(occ[k]), 64'(cnt[k]));
        if (!ov[k]) chk("idle_ctrl", k, 64'(oc[k]), 64'd0);
        if (ov[k] && out_ready) begin
          if (cnt[k] == 0) begin
            chk("spurious_beat", k, 64'd1, 64'd0);
          end else begin
            chk("beat_ctrl", k, 64'(oc[k]), 64'(mem[k][hd[k]].c));
            chk("beat_data", k, od[k], mem[k][hd[k]].d);
            hd[k]  = (hd[k] + 1) % 4;
            cnt[k] = cnt[k] - 1;
          end
        end
        if (flush) begin
          cnt[k] = 0;
        end else if (in_valid && exp_rdy) begin
          mem[k][(hd[k] + cnt[k]) % 4] = '{c: in_ctrl, d: in_data};
          cnt[k] = cnt[k] + 1;
        end
      end
    end
  end

  initial begin
    logic [63:0] v;
    logic        acc;
    #3;
    chk_reset_state();
    step();
    step();
    reset = 1'b0;

    // Back-to-back streaming with downstream always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 8'(i);
      in_data  = 64'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Stall from cycle 4 to 7; upstream holds its beat until the skid instance takes it.
    v = 64'd1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      in_valid  = 1'b1;
      in_data   = v;
      in_ctrl   = v[7:0];
      out_ready = !(cyc >= 4 && cyc <= 7);
      @(negedge clk);
      acc = rdy[1];
      if (cyc == 6) begin
        chk("stall_occ",   1, 64'(occ[1]), 64'd2);
        chk("stall_data",  1, od[1], 64'd3);
        chk("stall_ready", 1, 64'(rdy[1]), 64'd0);
      end
      step();
      if (acc) v = v + 1;
    end

    // Fill to FULL, then flush with a live input beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'hF00 + 64'(i);
      in_ctrl = 8'hC0 + 8'(i);
      step();
    end
    chk("full_occ", 1, 64'(occ[1]), 64'd2);
    flush   = 1'b1;
    in_data = 64'hDEAD;
    in_ctrl = 8'hDD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ",   1, 64'(occ[1]), 64'd0);
    chk("flush_valid", 1, 64'(ov[1]), 64'd0);
    chk("flush_ctrl",  1, 64'(oc[1]), 64'd0);
    step();

    // Reset while M holds a beat.
    in_valid = 1'b1;
    in_ctrl  = 8'hA5;
    in_data  = 64'h1234;
    step();
    in_valid = 1'b0;
    chk("held_data", 1, od[1], 64'h1234);
    chk("held_ctrl", 0, 64'(oc[0]), 64'hA5);
    #1 reset = 1'b1;
    #1 chk_reset_state();
    step();
    reset = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      in_ctrl   = 8'($urandom_range(0, 255));
      in_data   = {$urandom, $urandom};
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register that replaces the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB registers of the RV32 core. It carries an opaque payload split into a control field and a data field, and adds valid/ready flow control, stall, and flush (bubble insertion). An optional two-entry skid mode cuts the combinational ready path between stages. One instance sits between each pair of adjacent pipeline stages.

## Interface
- DATA_W, 64, width of the data payload (PC, operands, immediates, addresses).
- CTRL_W, 8, width of the control payload (RegWrite, MemRead, MemWrite, ALU op, …); forced to zero whenever the entry is empty.
- RESET_DATA, 0, value loaded into the data registers on reset.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries and of the current input beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control payload.
- in_data  in  DATA_W  upstream data payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  control payload; all zeros when out_valid=0.
- out_data  out  DATA_W  data payload; don't-care when out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Beat accepted on input: in_valid & in_ready & !flush. Beat consumed on output: out_valid & out_ready.
- Main entry (M) drives the outputs. out_ctrl = M.ctrl masked by M.valid.
- SKID=0:
  - in_ready = !M.valid | out_ready (combinational).
  - On accept, load M.
  - On consume without accept, clear M.valid.
- SKID=1:
  - in_ready = !S.valid (registered, no path from out_ready).
  - On accept with M empty or M consumed, load M, either from S when S.valid or from the input.
  - On accept while M holds and is not consumed, load the skid entry S.
  - On consume with S.valid, move S to M and clear S.
- States (SKID=1): EMPTY (M=0,S=0), HALF (M=1,S=0), FULL (M=1,S=1).
  - EMPTY to HALF on accept.
  - HALF stays HALF on accept+consume or on idle-stall.
  - HALF to EMPTY on consume only.
  - HALF to FULL on accept with out_ready=0.
  - FULL to HALF on consume. No accept is possible in FULL.
- flush:
  - Next edge: M.valid=S.valid=0 and both ctrl fields cleared. Data registers are unchanged.
  - The input beat in the flush cycle is dropped even if in_valid & in_ready.
  - flush has priority over every other event.
- Stall: out_ready=0 holds M bit-exact indefinitely.
- Ordering: strict FIFO; no beat is duplicated or lost except by flush.

## Timing
- Reset (async assert, sync deassert by the environment):
  - out_valid=0, out_ctrl=0, out_data=RESET_DATA, occupancy=0.
  - in_ready=1, in both modes.
- Latency: a beat accepted at edge N appears on out_* after edge N and is consumable in cycle N+1.
- Throughput: 1 beat/cycle sustained with out_ready=1, in both modes.
- SKID=1 back-pressure: after out_ready drops, in_ready falls one cycle later and exactly one extra beat is absorbed.
- Reset mid-transfer: all entries drop immediately, with no output glitch beyond the async clear.
- occupancy is registered and updates on the same edge as the entries.

## Structure
- Shared package pipe_pkg:
  - Typedefs for per-boundary control structs: if_id_ctrl_t, id_ex_ctrl_t, ex_mem_ctrl_t, mem_wb_ctrl_t.
  - Localparams for their widths, used as CTRL_W at instantiation.
  - NOP_CTRL = '0.
- Sub-module pipe_entry holds one valid/ctrl/data slot with load, clear and flush inputs. It is instantiated once for SKID=0 and twice (M, S) for SKID=1 via generate.
- Top level holds only the handshake/steering logic.

## Test plan
- Reset with reset=1 mid-beat (M holding ctrl=8'hA5, data=64'h1234) -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0 immediately.
- Streaming: 16 beats with data=i, ctrl=i, out_ready=1 -> each beat appears one cycle later in order, in_valid never blocked, for both SKID=0 and SKID=1.
- SKID=1 stall: stream data 1,2,3,… with out_ready low from cycle 4 -> in_ready=0 from cycle 5, occupancy=2, out_data holds 3 (skid holds 4); release out_ready -> 3,4,5 appear with no loss.
- flush while FULL (occupancy=2) with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and the flushed input beat never appears.
- flush and out_ready=1 with M valid in the same cycle -> the beat is consumed downstream this cycle, and the stage is empty the next cycle.
- Random valid/ready/flush, 10k cycles, against a queue model -> order preserved, out_ctrl=0 whenever out_valid=0, occupancy matches the model.
